sa_feeder: RTL

//  Transmit side of the systolic-array operand interface. Buffers one NxN A tile and one NxN B tile.
//  On start, streams the tiles diagonally skewed onto the array's a[]/b[] row/column inputs.

---
 rtl/sa_pkg.sv | 20 ++
 rtl/sa_feeder_if.sv | 29 ++
 rtl/sa_skew_lane.sv | 49 ++++
 rtl/sa_feeder.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array operand feeder.
//   SA_N           array dimension (rows = cols = reduction depth)
//   SA_DW          operand width (unsigned)
//   operand_t      one operand
//   feeder_state_t feeder sequencing states
package sa_pkg;

  localparam int SA_N  = 8;
  localparam int SA_DW = 8;

  typedef logic [SA_DW-1:0] operand_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/sa_feeder_if.sv
// Tile-loader write bus into the feeder.
//   in_valid  loader write strobe
//   in_ready  feeder accepts a write this cycle
//   in_sel    0 = A row write, 1 = B column write
//   in_idx    A row index i / B column index j
//   in_data   A[i][0..N-1] or B[0..N-1][j], element k in in_data[k]
// master = loader side, slave = feeder side.
interface sa_feeder_if #(
  parameter int N  = sa_pkg::SA_N,
  parameter int DW = sa_pkg::SA_DW
);

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_sel;
  logic [$clog2(N)-1:0]  in_idx;
  logic [N-1:0][DW-1:0]  in_data;

  modport master (
    output in_valid, in_sel, in_idx, in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_sel, in_idx, in_data,
    output in_ready
  );

endinterface

// File: rtl/sa_skew_lane.sv
// One skewed operand lane. Lane L emits buffer entry s-L while the
// stream counter s puts that entry inside the lane's window, else 0.
// The output is registered, so beat s shows up one cycle after s.
//   clk, rst   clock, asynchronous active-low reset
//   active     feeder is in its streaming phase
//   s          stream beat counter
//   lane_buf   the lane's N buffered operands
//   lane_out   registered operand for this lane
module sa_skew_lane #(
  parameter int N  = 8,
  parameter int DW = 8,
  parameter int CW = 5,
  parameter int L  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 active,
  input  logic [CW-1:0]        s,
  input  logic [N-1:0][DW-1:0] lane_buf,
  output logic [DW-1:0]        lane_out
);

  localparam int IW = $clog2(N);

  // One extra bit so s < L shows up as a negative (MSB set) offset.
  logic [CW:0]   diff_s;
  logic [DW-1:0] pick_s;

  // Select the in-window buffer entry for the current beat.
  always_comb begin
    diff_s = {1'b0, s} - (CW+1)'(L);
    pick_s = {DW{1'b0}};
    if (active && !diff_s[CW] && (diff_s[CW-1:0] < CW'(N))) begin
      pick_s = lane_buf[diff_s[IW-1:0]];
    end else begin
      pick_s = {DW{1'b0}};
    end
  end

  // Register the lane output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_out <= {DW{1'b0}};
    end else begin
      lane_out <= pick_s;
    end
  end

endmodule

// File: rtl/sa_feeder.sv
// Transmit side of the systolic-array operand interface.
// Buffers one NxN A tile (by rows) and one NxN B tile (by columns),
// streams them diagonally skewed on start, waits out the array
// fill/drain latency and pulses done when every result is final.
//   clk, rst   clock, asynchronous active-low reset
//   wr         tile-loader write bus (slave side)
//   start      begin streaming the buffered tiles (level, IDLE only)
//   busy       high from accepted start until done
//   done       one-cycle pulse: array results final
//   a_out      to sa.a[i], skewed row stream
//   b_out      to sa.b[j], skewed column stream
module sa_feeder import sa_pkg::*; #(
  parameter int N      = SA_N,
  parameter int DW     = SA_DW,
  parameter int PE_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  sa_feeder_if.slave           wr,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [N-1:0][DW-1:0] a_out,
  output logic [N-1:0][DW-1:0] b_out
);

  localparam int CW = $clog2(3*N);
  localparam logic [CW-1:0] STREAM_LAST = CW'(2*N-2);
  localparam logic [CW-1:0] DRAIN_LAST  = CW'(N-2+PE_LAT);

  feeder_state_t        state_r;
  logic [CW-1:0]        cnt_r;
  logic                 ready_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 wr_en_s;
  logic                 stream_s;

  // a_buf_r[i][k] = A[i][k]; b_buf_r[j][k] = B[k][j]. Storing B by
  // column makes both lane types index their slice with s-lane.
  logic [N-1:0][DW-1:0] a_buf_r [N];
  logic [N-1:0][DW-1:0] b_buf_r [N];

  // ready_r is only ever high in IDLE, so it alone qualifies writes.
  assign wr_en_s     = wr.in_valid & ready_r;
  assign stream_s    = (state_r == STREAM);
  assign wr.in_ready = ready_r;
  assign busy        = busy_r;
  assign done        = done_r;

  // Tile buffers: one full row/column per accepted write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        a_buf_r[i] <= '0;
        b_buf_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      if (wr.in_sel == 1'b0) begin
        a_buf_r[wr.in_idx] <= wr.in_data;
      end else begin
        b_buf_r[wr.in_idx] <= wr.in_data;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        a_buf_r[i] <= a_buf_r[i];
        b_buf_r[i] <= b_buf_r[i];
      end
    end
  end

  // Sequencer: IDLE -> STREAM -> DRAIN -> DONE -> IDLE, with
  // registered handshake/status outputs. done is raised on leaving
  // DONE so it lines up with the registered operand lanes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          cnt_r  <= {CW{1'b0}};
          if (start) begin
            state_r <= STREAM;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        STREAM: begin
          done_r <= 1'b0;
          if (cnt_r == STREAM_LAST) begin
            state_r <= DRAIN;
            cnt_r   <= {CW{1'b0}};
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DRAIN: begin
          done_r <= 1'b0;
          if (cnt_r == DRAIN_LAST) begin
            state_r <= DONE;
            cnt_r   <= {CW{1'b0}};
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
          cnt_r   <= {CW{1'b0}};
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CW{1'b0}};
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // N row lanes for A and N column lanes for B, lane g skewed by g beats.
  for (genvar g = 0; g < N; g++) begin : g_lane
    sa_skew_lane #(.N(N), .DW(DW), .CW(CW), .L(g)) u_a_lane (
      .clk      (clk),
      .rst      (rst),
      .active   (stream_s),
      .s        (cnt_r),
      .lane_buf (a_buf_r[g]),
      .lane_out (a_out[g])
    );
    sa_skew_lane #(.N(N), .DW(DW), .CW(CW), .L(g)) u_b_lane (
      .clk      (clk),
      .rst      (rst),
      .active   (stream_s),
      .s        (cnt_r),
      .lane_buf (b_buf_r[g]),
      .lane_out (b_out[g])
    );
  end

endmodule
